// File: rtl/eth_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_pkg
// Description : Shared constants for the Ethernet rx frame FIFO: default
//               buffer depth and counter width, the storage entry width
//               ({tlast, tdata}) and the write-side state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_rx_pkg;

    localparam int c_depth_log2_dflt = 11;
    localparam int c_cnt_w_dflt      = 16;

    // One stored entry is {tlast, tdata[7:0]}
    localparam int c_entry_w         = 9;

    // Write-side state machine encodings
    localparam logic [0:0] c_st_accept = 1'b0;
    localparam logic [0:0] c_st_drop   = 1'b1;

endpackage : eth_rx_pkg
`default_nettype wire

// File: rtl/eth_rx_sdp_ram.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_sdp_ram
// Description : Simple dual-port RAM, one write port and one read port on a
//               single clock. Read data is registered and only updates when
//               i_rd_en is high, so it holds its value while the consumer
//               stalls. The array itself has no reset.
// Ports       : clk        - clock
//               i_wr_en    - write strobe
//               i_wr_addr  - write address
//               i_wr_data  - write data
//               i_rd_en    - read strobe (updates o_rd_data next edge)
//               i_rd_addr  - read address
//               o_rd_data  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_sdp_ram
    import eth_rx_pkg::*;
#(
    parameter int ADDR_W = c_depth_log2_dflt,
    parameter int DATA_W = c_entry_w
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : eth_rx_sdp_ram
`default_nettype wire

// File: rtl/eth_rx_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_frame_fifo
// Description : Store-and-forward byte FIFO between the MAC rx client and the
//               rx unpacker. Frames are written speculatively and become
//               visible to the read side only once their last byte arrives
//               good. Bad frames and frames that overflow are rewound and
//               counted as drops.
// Ports       : i_axi_rx_clk / i_axi_rx_rst - clock, async active-high reset
//               i_mac_rx_*                  - unstallable MAC byte stream
//               o_rx_axis_fifo_* / i_..._tready - AXIS output to unpacker
//               o_good_frame_cnt            - committed frames (saturating)
//               o_drop_frame_cnt            - discarded frames (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_frame_fifo
    import eth_rx_pkg::*;
#(
    parameter int DEPTH_LOG2 = c_depth_log2_dflt,
    parameter int CNT_W      = c_cnt_w_dflt
) (
    input  logic             i_axi_rx_clk,
    input  logic             i_axi_rx_rst,
    input  logic [7:0]       i_mac_rx_tdata,
    input  logic             i_mac_rx_tvalid,
    input  logic             i_mac_rx_tlast,
    input  logic             i_mac_rx_tuser,
    output logic [7:0]       o_rx_axis_fifo_tdata,
    output logic             o_rx_axis_fifo_tvalid,
    output logic             o_rx_axis_fifo_tlast,
    input  logic             i_rx_axis_fifo_tready,
    output logic [CNT_W-1:0] o_good_frame_cnt,
    output logic [CNT_W-1:0] o_drop_frame_cnt
);

    localparam logic [DEPTH_LOG2-1:0] c_ptr_one = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_wr_commit;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [0:0]            r_wr_state;
    logic [0:0]            w_wr_state_nxt;
    logic [DEPTH_LOG2-1:0] w_wr_ptr_inc;
    logic                  w_full;
    logic                  w_wr_en;
    logic                  w_rewind;
    logic                  w_good_evt;
    logic                  w_drop_evt;

    assign w_wr_ptr_inc = r_wr_ptr + c_ptr_one;
    // One slot stays empty so that full and empty are distinguishable
    assign w_full       = (w_wr_ptr_inc == r_rd_ptr);

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_en        = 1'b0;
        w_rewind       = 1'b0;
        w_good_evt     = 1'b0;
        w_drop_evt     = 1'b0;
        if (i_mac_rx_tvalid) begin
            case (r_wr_state)
                c_st_accept: begin
                    if (i_mac_rx_tlast && i_mac_rx_tuser) begin
                        // Bad frame: throw away everything since last commit
                        w_rewind   = 1'b1;
                        w_drop_evt = 1'b1;
                    end else if (w_full) begin
                        w_rewind = 1'b1;
                        if (i_mac_rx_tlast) begin
                            w_drop_evt = 1'b1;
                        end else begin
                            w_wr_state_nxt = c_st_drop;
                        end
                    end else begin
                        w_wr_en    = 1'b1;
                        w_good_evt = i_mac_rx_tlast;
                    end
                end
                c_st_drop: begin
                    if (i_mac_rx_tlast) begin
                        w_drop_evt     = 1'b1;
                        w_wr_state_nxt = c_st_accept;
                    end
                end
                default: begin
                    w_wr_state_nxt = c_st_accept;
                end
            endcase
        end
    end

    always_ff @(posedge i_axi_rx_clk or posedge i_axi_rx_rst) begin
        if (i_axi_rx_rst) begin
            r_wr_state  <= c_st_accept;
            r_wr_ptr    <= '0;
            r_wr_commit <= '0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            if (w_wr_en) begin
                r_wr_ptr <= w_wr_ptr_inc;
            end else if (w_rewind) begin
                r_wr_ptr <= r_wr_commit;
            end
            if (w_good_evt) begin
                r_wr_commit <= w_wr_ptr_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame counters (saturating)
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_good_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    always_ff @(posedge i_axi_rx_clk or posedge i_axi_rx_rst) begin
        if (i_axi_rx_rst) begin
            r_good_cnt <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_good_evt && (r_good_cnt != '1)) begin
                r_good_cnt <= r_good_cnt + c_cnt_one;
            end
            if (w_drop_evt && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + c_cnt_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic                 w_rd_en;
    logic [c_entry_w-1:0] w_ram_q;

    eth_rx_sdp_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (c_entry_w)
    ) u_ram (
        .clk       (i_axi_rx_clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data ({i_mac_rx_tlast, i_mac_rx_tdata}),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_ram_q)
    );

    // ------------------------------------------------------------------
    // Read side: RAM output stage (r_ram_vld) feeding a show-ahead register.
    // The RAM stage refills whenever it is empty or being moved forward,
    // which keeps the path at one byte per clock.
    // ------------------------------------------------------------------
    logic       r_ram_vld;
    logic       r_out_vld;
    logic [7:0] r_out_data;
    logic       r_out_last;
    logic       w_out_ld;
    logic       w_ram_adv;

    assign w_out_ld  = r_ram_vld && (!r_out_vld || i_rx_axis_fifo_tready);
    assign w_ram_adv = !r_ram_vld || w_out_ld;
    // Only committed bytes are visible: compare against wr_commit, not wr_ptr
    assign w_rd_en   = (r_rd_ptr != r_wr_commit) && w_ram_adv;

    always_ff @(posedge i_axi_rx_clk or posedge i_axi_rx_rst) begin
        if (i_axi_rx_rst) begin
            r_rd_ptr   <= '0;
            r_ram_vld  <= 1'b0;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
        end else begin
            if (w_rd_en) begin
                r_rd_ptr  <= r_rd_ptr + c_ptr_one;
                r_ram_vld <= 1'b1;
            end else if (w_out_ld) begin
                r_ram_vld <= 1'b0;
            end
            if (w_out_ld) begin
                r_out_vld  <= 1'b1;
                r_out_data <= w_ram_q[7:0];
                r_out_last <= w_ram_q[8];
            end else if (i_rx_axis_fifo_tready) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    assign o_rx_axis_fifo_tdata  = r_out_data;
    assign o_rx_axis_fifo_tvalid = r_out_vld;
    assign o_rx_axis_fifo_tlast  = r_out_last;
    assign o_good_frame_cnt      = r_good_cnt;
    assign o_drop_frame_cnt      = r_drop_cnt;

endmodule : eth_rx_frame_fifo
`default_nettype wire

// File: tb/tb_eth_rx_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_rx_frame_fifo
// Description : Directed self-checking bench for eth_rx_frame_fifo. Two
//               instances (default depth and DEPTH_LOG2=6) share one stimulus
//               bus selected by r_sel; a scoreboard of expected {tlast,data}
//               beats is filled by the frame sender and drained by the
//               output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_rx_frame_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r_sel = 1'b0;
    logic [7:0]  m_tdata = '0;
    logic        m_tvalid = 1'b0;
    logic        m_tlast = 1'b0;
    logic        m_tuser = 1'b0;
    logic        rdy = 1'b1;
    int          rdy_mode = 1;

    logic [7:0]  a_data, b_data;
    logic        a_vld, b_vld, a_last, b_last;
    logic [15:0] a_good, a_drop, b_good, b_drop;

    logic [7:0]  o_data;
    logic        o_vld, o_last;
    logic [15:0] o_good, o_drop;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    eth_rx_frame_fifo u_dut_big (
        .i_axi_rx_clk          (clk),
        .i_axi_rx_rst          (rst),
        .i_mac_rx_tdata        (m_tdata),
        .i_mac_rx_tvalid       (m_tvalid && !r_sel),
        .i_mac_rx_tlast        (m_tlast),
        .i_mac_rx_tuser        (m_tuser),
        .o_rx_axis_fifo_tdata  (a_data),
        .o_rx_axis_fifo_tvalid (a_vld),
        .o_rx_axis_fifo_tlast  (a_last),
        .i_rx_axis_fifo_tready (rdy),
        .o_good_frame_cnt      (a_good),
        .o_drop_frame_cnt      (a_drop)
    );

    eth_rx_frame_fifo #(.DEPTH_LOG2(6), .CNT_W(16)) u_dut_small (
        .i_axi_rx_clk          (clk),
        .i_axi_rx_rst          (rst),
        .i_mac_rx_tdata        (m_tdata),
        .i_mac_rx_tvalid       (m_tvalid && r_sel),
        .i_mac_rx_tlast        (m_tlast),
        .i_mac_rx_tuser        (m_tuser),
        .o_rx_axis_fifo_tdata  (b_data),
        .o_rx_axis_fifo_tvalid (b_vld),
        .o_rx_axis_fifo_tlast  (b_last),
        .i_rx_axis_fifo_tready (rdy),
        .o_good_frame_cnt      (b_good),
        .o_drop_frame_cnt      (b_drop)
    );

    assign o_data = r_sel ? b_data : a_data;
    assign o_vld  = r_sel ? b_vld  : a_vld;
    assign o_last = r_sel ? b_last : a_last;
    assign o_good = r_sel ? b_good : a_good;
    assign o_drop = r_sel ? b_drop : a_drop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // tready driver: 0 = held low, 1 = held high, 2 = random 50%
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 2) rdy = 1'($urandom_range(0, 1));
            else               rdy = (rdy_mode == 1);
        end
    end

    // Output monitor: scoreboard compare on handshake, stability under stall
    initial begin
        logic       prev_stall;
        logic [8:0] prev_beat;
        logic [8:0] e;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) check("hold", {o_vld, o_last, o_data}, {1'b1, prev_beat});
                if (o_vld && rdy) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", {o_last, o_data}, e);
                    end
                end
                prev_stall = o_vld && !rdy;
                prev_beat  = {o_last, o_data};
            end
        end
    end

    task automatic beat(input logic [7:0] d, input logic l, input logic u);
        @(posedge clk);
        #1;
        m_tvalid = 1'b1;
        m_tdata  = d;
        m_tlast  = l;
        m_tuser  = u;
    endtask

    task automatic mac_idle();
        @(posedge clk);
        #1;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        m_tuser  = 1'b0;
    endtask

    task automatic send_frame(input int len, input int base, input bit bad, input bit keep);
        logic [7:0] d;
        logic       l;
        for (int i = 0; i < len; i++) begin
            d = 8'(base + i);
            l = (i == len - 1);
            beat(d, l, bad && l);
            if (keep) exp_q.push_back({l, d});
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst      = 1'b1;
        m_tvalid = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_vld", o_vld, 0);
        check("rst_good", o_good, 0);
        check("rst_drop", o_drop, 0);

        // 1: single 64-byte good frame
        send_frame(64, 0, 0, 1);
        mac_idle();
        wait_drain("t1_drain");
        check("t1_good", o_good, 1);
        check("t1_drop", o_drop, 0);

        // 2: bad frame followed by a good frame
        apply_reset();
        send_frame(60, 8'h40, 1, 0);
        send_frame(60, 8'h80, 0, 1);
        mac_idle();
        wait_drain("t2_drain");
        check("t2_good", o_good, 1);
        check("t2_drop", o_drop, 1);

        // 4: three back-to-back frames with random backpressure
        apply_reset();
        rdy_mode = 2;
        send_frame(17, 8'h10, 0, 1);
        send_frame(1, 8'hA5, 0, 1);
        send_frame(100, 8'h20, 0, 1);
        mac_idle();
        wait_drain("t4_drain");
        check("t4_good", o_good, 3);
        check("t4_drop", o_drop, 0);

        // 5: commit latency, then async reset in the middle of a frame
        apply_reset();
        rdy_mode = 0;
        send_frame(5, 8'h60, 0, 1);
        mac_idle();
        check("t5_lat_early", o_vld, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("t5_lat_due", o_vld, 1);
        for (int i = 0; i < 20; i++) beat(8'(8'h70 + i), 1'b0, 1'b0);
        #3;
        rst      = 1'b1;
        m_tvalid = 1'b0;
        #1;
        check("t5_async_vld", o_vld, 0);
        check("t5_async_data", o_data, 0);
        check("t5_async_good", o_good, 0);
        exp_q.delete();
        rdy_mode = 1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("t5_post_idle", o_vld, 0);
        send_frame(8, 8'h90, 0, 1);
        mac_idle();
        wait_drain("t5_drain");
        check("t5_good", o_good, 1);

        // 3: small FIFO overflow with output stalled
        r_sel = 1'b1;
        apply_reset();
        rdy_mode = 0;
        send_frame(40, 8'h00, 0, 1);
        send_frame(40, 8'h30, 0, 0);
        mac_idle();
        repeat (5) @(posedge clk);
        #1;
        check("t3_drop", o_drop, 1);
        check("t3_good", o_good, 1);
        rdy_mode = 1;
        wait_drain("t3_drain");

        // 6: ten 50-byte frames through the small FIFO, pointer wrap
        apply_reset();
        rdy_mode = 1;
        for (int k = 0; k < 10; k++) send_frame(50, k * 50, 0, 1);
        mac_idle();
        wait_drain("t6_drain");
        check("t6_good", o_good, 10);
        check("t6_drop", o_drop, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_eth_rx_frame_fifo
`default_nettype wire
